traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker that sits on the lamp outputs of the two-street traffic light controller and decodes them back into signal phases. It verifies that the phases are mutually safe, follow the legal rotation, and hold for the programmed green and yellow durations. It counts completed rotations and reports sticky fault flags. It is used in simulation and can also be instantiated on the board next to the controller, with its outputs routed to debug LEDs.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `GREEN_TIME`, default 20: expected green dwell in seconds.
- `YELLOW_TIME`, default 5: expected yellow dwell in seconds.
- `TOL_CYCLES`, default 2: allowed ± deviation in cycles for each dwell.
- `clk_i` input, 1 bit: the block's single clock.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `street1_i` input, 3 bits: street 1 lamps as {red, yellow, green}.
- `street2_i` input, 3 bits: street 2 lamps as {red, yellow, green}.
- `clear_i` input, 1 bit: synchronous pulse that clears the sticky fault flags.
- `phase_o` output, 2 bits: current phase, 0=G1, 1=Y1, 2=G2, 3=Y2.
- `phase_valid_o` output, 1 bit: set while the monitor is in TRACK.
- `fault_flags_o` output, 5 bits, sticky: [0] conflict, [1] invalid pattern, [2] sequence, [3] dwell short, [4] dwell long.
- `fault_o` output, 1 bit: OR of `fault_flags_o`.
- `cycles_o` output, 16 bits: completed rotations; wraps modulo 2^16.

## Operation
- The block first registers `street1_i` and `street2_i`. All checks run on the registered pattern P.
- Each street decodes as follows: 001 = green, 010 = yellow, 100 = red, 000 = dark, anything else = invalid.
- Legal phases:
  - G1: street 1 green, street 2 red.
  - Y1: street 1 yellow, street 2 red.
  - G2: street 1 red, street 2 green.
  - Y2: street 1 red, street 2 yellow.
- Fault classification:
  - Conflict: both streets valid and neither is red.
  - Invalid: either street is invalid, or exactly one street is dark.
  - Both streets dark counts as invalid only in TRACK.
- Green dwell is GREEN_CYC = CLK_FREQ*GREEN_TIME cycles. Yellow dwell is YELLOW_CYC = CLK_FREQ*YELLOW_TIME cycles.
- Dwell counter D:
  - D is 1 on the first cycle a phase is present in P and increments each cycle after.
  - D saturates and never wraps.
  - Its width is $clog2(GREEN_CYC+TOL_CYCLES+2).
- State machine:
  - START (reset state):
    - 000/000 stays in START.
    - G1 goes to TRACK with D=1.
    - Any other legal phase sets sequence fault and goes to SYNC.
    - A conflict or invalid pattern sets the matching flag and goes to SYNC.
  - TRACK, when P is unchanged: D increments. When D reaches expected+TOL_CYCLES+1, the block sets dwell-long and goes to SYNC.
  - TRACK, when P changes to the legal successor (G1→Y1→G2→Y2→G1):
    - If the previous D < expected−TOL_CYCLES, the block sets dwell-short.
    - The block stays in TRACK in any case, with D=1.
    - On a Y2→G1 transition, `cycles_o` increments.
  - TRACK, when P changes to any other legal phase: the block sets sequence fault and goes to SYNC.
  - TRACK, when P is a conflict or invalid pattern: the block sets the matching flag and goes to SYNC.
  - SYNC: the block waits for P to change into a legal phase, then enters TRACK in that phase with D=1. No dwell or sequence check applies on that entry.
- Flags are only set, never cleared, by checks.
- `clear_i` zeroes all flags. If a new fault is detected in the same cycle, that fault's bit is set and the remaining bits are cleared.
- `clear_i` does not change state, D or `cycles_o`.

## Timing
- Reset values: `phase_o`=0, `phase_valid_o`=0, `fault_flags_o`=0, `fault_o`=0, `cycles_o`=0. The state is START, D=0, and the input register is 000/000.
- Asserting `rst_i` at any time forces these values immediately, without waiting for a clock edge. No fault is raised by a reset in mid-operation.
- Latency from a pattern change on the input ports to the updated `phase_o`, `fault_flags_o` or `cycles_o` is two rising edges: one edge for the input register, one for the output and state register.
- `fault_o` is derived combinationally from the registered flags, so it has the same latency.
- With one-cycle glitch patterns, each glitch cycle is evaluated on its own.
- At most one of the conflict or invalid flags is set per cycle. When both conditions apply, invalid takes precedence.

## Test plan
Unless stated otherwise, all scenarios use CLK_FREQ=10, GREEN_TIME=2, YELLOW_TIME=1, TOL_CYCLES=2, which gives GREEN_CYC=20 and YELLOW_CYC=10.
- Legal run: reset, then 000/000 for 3 cycles, then G1 for 20 cycles, Y1 for 10, G2 for 20, Y2 for 10, then G1. Required: `fault_flags_o`=0 throughout, `phase_o` steps 0,1,2,3,0, and `cycles_o`=1 two edges after G1 is applied.
- Conflict: in TRACK during G1, apply 001/001 for one cycle. Required: `fault_flags_o`=5'b00001 two edges later and `phase_valid_o`=0. After Y1 is applied, the block resumes TRACK with `phase_o`=1.
- Invalid pattern: apply street 1 = 011 during Y1. Required: `fault_flags_o`[1]=1. Then pulse `clear_i`. Required: flags return to 0.
- Sequence error: apply G1 for 20 cycles, then G2. Required: `fault_flags_o`=5'b00100.
- Dwell errors:
  - G1 held for 17 cycles, then Y1. Required: `fault_flags_o`[3]=1 and the block stays in TRACK.
  - G1 held continuously. Required: `fault_flags_o`[4]=1 when D=23 is reached.
- Reset mid-operation: assert `rst_i` halfway through Y2 with `cycles_o`=3 and a flag set. Required: every output is 0 immediately, before the next clock edge, and the block is back in START.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-street traffic light controller: decodes lamp
// outputs into phases and flags unsafe patterns, bad rotation order and bad dwell times.
module traffic_light_monitor #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned GREEN_TIME  = 20,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned TOL_CYCLES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  street1_i,
    input  logic [2:0]  street2_i,
    input  logic        clear_i,
    output logic [1:0]  phase_o,
    output logic        phase_valid_o,
    output logic [4:0]  fault_flags_o,
    output logic        fault_o,
    output logic [15:0] cycles_o
);

    localparam int unsigned GREEN_CYC  = CLK_FREQ * GREEN_TIME;
    localparam int unsigned YELLOW_CYC = CLK_FREQ * YELLOW_TIME;
    localparam int unsigned DW         = $clog2(GREEN_CYC + TOL_CYCLES + 2);

    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_SYNC  = 2'd2;

    localparam int unsigned F_CONFLICT = 0;
    localparam int unsigned F_INVALID  = 1;
    localparam int unsigned F_SEQUENCE = 2;
    localparam int unsigned F_SHORT    = 3;
    localparam int unsigned F_LONG     = 4;

    logic [5:0]    pat_q;
    logic [5:0]    pat_prev_q;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic [DW-1:0] dwell_inc;
    logic [1:0]    phase_d;
    logic          valid_d;
    logic [15:0]   cycles_d;
    logic [4:0]    new_flags;
    logic [4:0]    flags_d;

    logic [2:0]    s1;
    logic [2:0]    s2;
    logic          s1_bad;
    logic          s2_bad;
    logic          s1_dark;
    logic          s2_dark;
    logic          invalid_pat;
    logic          both_dark;
    logic          conflict_pat;
    logic          legal;
    logic [1:0]    pat_phase;
    logic          pat_changed;
    int unsigned   exp_cyc;

    // Decode the registered lamp pattern into fault classes and a phase.
    always_comb begin
        s1           = pat_q[5:3];
        s2           = pat_q[2:0];
        s1_bad       = !(s1 inside {LAMP_G, LAMP_Y, LAMP_R, LAMP_OFF});
        s2_bad       = !(s2 inside {LAMP_G, LAMP_Y, LAMP_R, LAMP_OFF});
        s1_dark      = (s1 == LAMP_OFF);
        s2_dark      = (s2 == LAMP_OFF);
        invalid_pat  = s1_bad | s2_bad | (s1_dark ^ s2_dark);
        both_dark    = s1_dark & s2_dark;
        conflict_pat = !s1_bad && !s2_bad && !s1_dark && !s2_dark
                       && (s1 != LAMP_R) && (s2 != LAMP_R);
        legal        = 1'b0;
        pat_phase    = 2'd0;
        case (pat_q)
            {LAMP_G, LAMP_R}: begin legal = 1'b1; pat_phase = 2'd0; end
            {LAMP_Y, LAMP_R}: begin legal = 1'b1; pat_phase = 2'd1; end
            {LAMP_R, LAMP_G}: begin legal = 1'b1; pat_phase = 2'd2; end
            {LAMP_R, LAMP_Y}: begin legal = 1'b1; pat_phase = 2'd3; end
            default:          begin legal = 1'b0; pat_phase = 2'd0; end
        endcase
        pat_changed = (pat_q != pat_prev_q);
        exp_cyc     = phase_o[0] ? YELLOW_CYC : GREEN_CYC;
        dwell_inc   = (dwell_q == {DW{1'b1}}) ? dwell_q : dwell_q + DW'(1);
    end

    // Next-state, dwell, rotation and fault logic.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        phase_d   = phase_o;
        valid_d   = phase_valid_o;
        cycles_d  = cycles_o;
        new_flags = 5'b0;
        case (state_q)
            S_START: begin
                if (invalid_pat) begin
                    new_flags[F_INVALID] = 1'b1;
                    state_d              = S_SYNC;
                end else if (conflict_pat) begin
                    new_flags[F_CONFLICT] = 1'b1;
                    state_d               = S_SYNC;
                end else if (both_dark) begin
                    state_d = S_START;
                end else if (legal && (pat_phase == 2'd0)) begin
                    state_d = S_TRACK;
                    dwell_d = DW'(1);
                    phase_d = 2'd0;
                    valid_d = 1'b1;
                end else begin
                    new_flags[F_SEQUENCE] = 1'b1;
                    state_d               = S_SYNC;
                end
            end
            S_TRACK: begin
                if (invalid_pat || both_dark) begin
                    new_flags[F_INVALID] = 1'b1;
                    state_d              = S_SYNC;
                end else if (conflict_pat) begin
                    new_flags[F_CONFLICT] = 1'b1;
                    state_d               = S_SYNC;
                end else if (!legal) begin
                    new_flags[F_SEQUENCE] = 1'b1;
                    state_d               = S_SYNC;
                end else if (!pat_changed) begin
                    dwell_d = dwell_inc;
                    if (32'(dwell_inc) >= exp_cyc + TOL_CYCLES + 1) begin
                        new_flags[F_LONG] = 1'b1;
                        state_d           = S_SYNC;
                    end
                end else if (pat_phase == phase_o + 2'd1) begin
                    if (32'(dwell_q) + TOL_CYCLES < exp_cyc) begin
                        new_flags[F_SHORT] = 1'b1;
                    end
                    dwell_d = DW'(1);
                    phase_d = pat_phase;
                    if (phase_o == 2'd3) begin
                        cycles_d = cycles_o + 16'd1;
                    end
                end else begin
                    new_flags[F_SEQUENCE] = 1'b1;
                    state_d               = S_SYNC;
                end
            end
            S_SYNC: begin
                if (invalid_pat) begin
                    new_flags[F_INVALID] = 1'b1;
                end else if (conflict_pat) begin
                    new_flags[F_CONFLICT] = 1'b1;
                end else if (legal && pat_changed) begin
                    state_d = S_TRACK;
                    dwell_d = DW'(1);
                    phase_d = pat_phase;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
        // Leaving TRACK always drops the phase qualifier and the dwell count.
        if (state_d != S_TRACK) begin
            valid_d = 1'b0;
            if (state_d == S_SYNC) begin
                dwell_d = '0;
            end
        end
        flags_d = clear_i ? new_flags : (fault_flags_o | new_flags);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pat_q         <= 6'b0;
            pat_prev_q    <= 6'b0;
            state_q       <= S_START;
            dwell_q       <= '0;
            phase_o       <= 2'd0;
            phase_valid_o <= 1'b0;
            fault_flags_o <= 5'b0;
            cycles_o      <= 16'd0;
        end else begin
            pat_q         <= {street1_i, street2_i};
            pat_prev_q    <= pat_q;
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            phase_o       <= phase_d;
            phase_valid_o <= valid_d;
            fault_flags_o <= flags_d;
            cycles_o      <= cycles_d;
        end
    end

    assign fault_o = |fault_flags_o;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with small timing parameters
// (green dwell 20 cycles, yellow dwell 10 cycles, tolerance 2).
module tb_traffic_light_monitor;

    localparam logic [5:0] PDARK = 6'b000_000;
    localparam logic [5:0] PG1   = 6'b001_100;
    localparam logic [5:0] PY1   = 6'b010_100;
    localparam logic [5:0] PG2   = 6'b100_001;
    localparam logic [5:0] PY2   = 6'b100_010;
    localparam logic [5:0] PCONF = 6'b001_001;
    localparam logic [5:0] PINV  = 6'b011_100;

    logic        clk;
    logic        rst;
    logic [2:0]  street1;
    logic [2:0]  street2;
    logic        clear;
    logic [1:0]  phase;
    logic        phase_valid;
    logic [4:0]  fault_flags;
    logic        fault;
    logic [15:0] cycles;

    int total;
    int bad;

    traffic_light_monitor #(
        .CLK_FREQ   (10),
        .GREEN_TIME (2),
        .YELLOW_TIME(1),
        .TOL_CYCLES (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .street1_i    (street1),
        .street2_i    (street2),
        .clear_i      (clear),
        .phase_o      (phase),
        .phase_valid_o(phase_valid),
        .fault_flags_o(fault_flags),
        .fault_o      (fault),
        .cycles_o     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] p);
        {street1, street2} = p;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        clear = 1'b0;
        drive(PDARK);
        hold(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        clear = 1'b0;
        drive(PDARK);
        #1;
        total++; if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", phase_valid); end
        total++; if (fault_flags !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", fault_flags); end
        total++; if (cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
        hold(2);
        rst = 1'b0;
        hold(3);
        total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL start_dark_valid got=%0b want=0", phase_valid); end
    endtask

    task automatic test_legal_run();
        do_reset();
        hold(3);
        drive(PG1); hold(2);
        total++; if (phase_valid !== 1'b1 || phase !== 2'd0) begin bad++; $display("FAIL legal_g1 valid=%0b phase=%0d want valid=1 phase=0", phase_valid, phase); end
        hold(18);
        drive(PY1); hold(2);
        total++; if (phase !== 2'd1) begin bad++; $display("FAIL legal_y1 got=%0d want=1", phase); end
        hold(8);
        drive(PG2); hold(2);
        total++; if (phase !== 2'd2) begin bad++; $display("FAIL legal_g2 got=%0d want=2", phase); end
        hold(18);
        drive(PY2); hold(1);
        total++; if (cycles !== 16'd0) begin bad++; $display("FAIL legal_cycles_early got=%0d want=0", cycles); end
        hold(1);
        total++; if (phase !== 2'd3) begin bad++; $display("FAIL legal_y2 got=%0d want=3", phase); end
        hold(8);
        drive(PG1); hold(1);
        total++; if (cycles !== 16'd0) begin bad++; $display("FAIL legal_cycles_one_edge got=%0d want=0", cycles); end
        hold(1);
        total++; if (phase !== 2'd0 || cycles !== 16'd1) begin bad++; $display("FAIL legal_wrap phase=%0d cycles=%0d want phase=0 cycles=1", phase, cycles); end
        total++; if (fault_flags !== 5'b0 || fault !== 1'b0) begin bad++; $display("FAIL legal_flags got=%b fault=%0b want=00000 fault=0", fault_flags, fault); end
    endtask

    task automatic test_conflict();
        do_reset();
        drive(PG1); hold(10);
        drive(PCONF); hold(1);
        drive(PY1); hold(1);
        total++; if (fault_flags !== 5'b00001) begin bad++; $display("FAIL conflict_flags got=%b want=00001", fault_flags); end
        total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL conflict_valid got=%0b want=0", phase_valid); end
        hold(1);
        total++; if (phase_valid !== 1'b1 || phase !== 2'd1) begin bad++; $display("FAIL conflict_resume valid=%0b phase=%0d want valid=1 phase=1", phase_valid, phase); end
    endtask

    task automatic test_invalid_clear();
        do_reset();
        drive(PG1); hold(20);
        drive(PY1); hold(3);
        drive(PINV); hold(1);
        drive(PY1); hold(1);
        total++; if (fault_flags !== 5'b00010 || fault !== 1'b1) begin bad++; $display("FAIL invalid_flags got=%b fault=%0b want=00010 fault=1", fault_flags, fault); end
        hold(1);
        total++; if (phase_valid !== 1'b1 || phase !== 2'd1) begin bad++; $display("FAIL invalid_resume valid=%0b phase=%0d want valid=1 phase=1", phase_valid, phase); end
        clear = 1'b1; hold(1);
        clear = 1'b0;
        total++; if (fault_flags !== 5'b0 || fault !== 1'b0) begin bad++; $display("FAIL clear_flags got=%b fault=%0b want=00000 fault=0", fault_flags, fault); end
        total++; if (phase_valid !== 1'b1 || phase !== 2'd1) begin bad++; $display("FAIL clear_state valid=%0b phase=%0d want valid=1 phase=1", phase_valid, phase); end
    endtask

    task automatic test_sequence();
        do_reset();
        drive(PG1); hold(20);
        drive(PG2); hold(2);
        total++; if (fault_flags !== 5'b00100) begin bad++; $display("FAIL sequence_flags got=%b want=00100", fault_flags); end
        total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL sequence_valid got=%0b want=0", phase_valid); end
    endtask

    task automatic test_dwell_short();
        do_reset();
        drive(PG1); hold(17);
        drive(PY1); hold(2);
        total++; if (fault_flags !== 5'b01000) begin bad++; $display("FAIL short_flags got=%b want=01000", fault_flags); end
        total++; if (phase_valid !== 1'b1 || phase !== 2'd1) begin bad++; $display("FAIL short_track valid=%0b phase=%0d want valid=1 phase=1", phase_valid, phase); end
    endtask

    task automatic test_dwell_long();
        do_reset();
        drive(PG1); hold(23);
        total++; if (fault_flags !== 5'b0) begin bad++; $display("FAIL long_early got=%b want=00000", fault_flags); end
        hold(1);
        total++; if (fault_flags !== 5'b10000) begin bad++; $display("FAIL long_flags got=%b want=10000", fault_flags); end
        total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL long_valid got=%0b want=0", phase_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(PG1); hold((r == 0) ? 17 : 20);
            drive(PY1); hold(10);
            drive(PG2); hold(20);
            drive(PY2); hold(10);
        end
        drive(PG1); hold(20);
        drive(PY1); hold(10);
        drive(PG2); hold(20);
        drive(PY2); hold(5);
        total++; if (cycles !== 16'd3 || fault_flags !== 5'b01000) begin bad++; $display("FAIL mid_pre cycles=%0d flags=%b want cycles=3 flags=01000", cycles, fault_flags); end
        #2;
        rst = 1'b1;
        drive(PDARK);
        #1;
        total++; if (phase !== 2'd0 || phase_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_phase phase=%0d valid=%0b want 0 0", phase, phase_valid); end
        total++; if (fault_flags !== 5'b0 || fault !== 1'b0) begin bad++; $display("FAIL mid_rst_flags flags=%b fault=%0b want 00000 0", fault_flags, fault); end
        total++; if (cycles !== 16'd0) begin bad++; $display("FAIL mid_rst_cycles got=%0d want=0", cycles); end
        hold(2);
        rst = 1'b0;
        hold(3);
        total++; if (phase_valid !== 1'b0 || fault_flags !== 5'b0) begin bad++; $display("FAIL mid_start valid=%0b flags=%b want 0 00000", phase_valid, fault_flags); end
        drive(PG1); hold(2);
        total++; if (phase_valid !== 1'b1 || phase !== 2'd0 || fault_flags !== 5'b0) begin bad++; $display("FAIL mid_restart valid=%0b phase=%0d flags=%b want 1 0 00000", phase_valid, phase, fault_flags); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        street1 = 3'b000;
        street2 = 3'b000;
        test_reset();
        test_legal_run();
        test_conflict();
        test_invalid_clear();
        test_sequence();
        test_dwell_short();
        test_dwell_long();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
